fpu_norm_round: RTL

Two-stage pipelined normalize-and-round stage that sits directly downstream of the floating-point multiplier. It takes the multiplier's sign, prenormalized signed exponent and raw double-width mantissa product, and normalizes them, including subnormal and underflow handling. It then rounds per the requested RISC-V rounding mode and emits a packed IEEE-754 result with exception flags. Input and output use valid/ready handshakes with full backpressure.

---
 rtl/fpu_norm_round.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fpu_norm_round.sv
// Normalize-and-round stage behind the FP multiplier.
// Two elastic pipeline stages: stage 1 normalizes the raw product
// (including subnormal/underflow alignment); stage 2 rounds, packs and flags.
// Ports:
//   Clk_CI, Rst_RI            clock, async active-high reset
//   Flush_SI                  drop all in-flight items on the next edge
//   Valid_SI / Ready_SO       input handshake
//   Sign/Exp/Mant_prenorm_DI  sign, signed biased exponent of product bit 2*C_MANT, raw product
//   RM_SI                     rounding mode (0 RNE,1 RTZ,2 RDN,3 RUP,4 RMM, else RNE)
//   Valid_SO / Ready_SI       output handshake
//   Result_DO                 packed {sign, exp, frac}
//   OF_SO, UF_SO, NX_SO       overflow, underflow, inexact
module fpu_norm_round #(
    parameter int unsigned C_EXP          = 8,
    parameter int unsigned C_MANT         = 23,
    parameter int unsigned C_BIAS         = 127,
    parameter int unsigned C_EXP_PRENORM  = C_EXP + 2,
    parameter int unsigned C_MANT_PRENORM = 2 * (C_MANT + 1)
) (
    input  logic                        Clk_CI,
    input  logic                        Rst_RI,
    input  logic                        Flush_SI,
    input  logic                        Valid_SI,
    output logic                        Ready_SO,
    input  logic                        Sign_prenorm_DI,
    input  logic [C_EXP_PRENORM-1:0]    Exp_prenorm_DI,
    input  logic [C_MANT_PRENORM-1:0]   Mant_prenorm_DI,
    input  logic [2:0]                  RM_SI,
    output logic                        Valid_SO,
    input  logic                        Ready_SI,
    output logic [C_EXP+C_MANT:0]       Result_DO,
    output logic                        OF_SO,
    output logic                        UF_SO,
    output logic                        NX_SO
);

    localparam int unsigned W   = C_MANT_PRENORM;
    localparam int unsigned MW  = C_MANT + 1;
    localparam int unsigned EW  = C_EXP + 2;
    localparam int unsigned XW  = C_EXP_PRENORM + 2;
    localparam int unsigned LZW = $clog2(W);
    localparam int unsigned SW  = 1 + EW + C_MANT;
    localparam int unsigned RW  = C_EXP + C_MANT + 1;

    // Leading-zero count of the product below the integer-overflow bit.
    function automatic logic [LZW-1:0] lzc(input logic [W-2:0] v);
        lzc = LZW'(W - 1);
        for (int i = 0; i < int'(W) - 1; i++) begin
            if (v[i]) lzc = LZW'(int'(W) - 2 - i);
        end
    endfunction

    // Handshake control
    logic v1, v2;
    logic in_fire, s1_move, pop;

    assign Ready_SO = !v1 | !v2 | Ready_SI;
    assign in_fire  = Valid_SI & Ready_SO;
    assign s1_move  = v1 & (!v2 | Ready_SI);
    assign pop      = v2 & Ready_SI;
    assign Valid_SO = v2;

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (Flush_SI) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (in_fire)      v1 <= 1'b1;
            else if (s1_move) v1 <= 1'b0;
            if (s1_move)      v2 <= 1'b1;
            else if (pop)     v2 <= 1'b0;
        end
    end

    // Stage 1: normalize
    logic           top, st0, st;
    logic [W-1:0]   sh1, norm;
    logic [XW-1:0]  e1, rs, lsh;
    logic [EW-1:0]  nexp;
    logic [LZW-1:0] lz;

    always_comb begin
        top  = Mant_prenorm_DI[W-1];
        lz   = lzc(Mant_prenorm_DI[W-2:0]);
        e1   = XW'($signed(Exp_prenorm_DI)) + XW'(top);
        sh1  = top ? (Mant_prenorm_DI >> 1) : Mant_prenorm_DI;
        st0  = top & Mant_prenorm_DI[0];
        norm = sh1;
        st   = st0;
        nexp = EW'(e1);
        rs   = '0;
        lsh  = '0;
        if (Mant_prenorm_DI == '0) begin
            norm = '0;
            st   = 1'b0;
            nexp = '0;
        end else if (e1[XW-1] || e1 == '0) begin
            // Below the normal range: align to the subnormal quantum.
            rs = XW'(1) - e1;
            if (rs > XW'(W)) rs = XW'(W);
            norm = sh1 >> rs;
            st   = st0 | (|(sh1 & ~({W{1'b1}} << rs)));
            nexp = '0;
        end else if (!top) begin
            // Left shift is capped so the exponent never drops below 1.
            if (e1 - XW'(1) < XW'(lz)) begin
                lsh  = e1 - XW'(1);
                nexp = '0;
            end else begin
                lsh  = XW'(lz);
                nexp = EW'(e1 - XW'(lz));
            end
            norm = sh1 << lsh;
        end
    end

    logic               s1_sign, s1_guard, s1_sticky;
    logic [2:0]         s1_rm;
    logic [EW-1:0]      s1_exp;
    logic [C_MANT-1:0]  s1_frac;
    logic               unused_bits;

    // Hidden bit is implied by the exponent field, so it is not stored.
    assign unused_bits = ^{norm[W-1], norm[W-2]};

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            s1_sign   <= 1'b0;
            s1_rm     <= '0;
            s1_exp    <= '0;
            s1_frac   <= '0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
        end else if (in_fire) begin
            s1_sign   <= Sign_prenorm_DI;
            s1_rm     <= RM_SI;
            s1_exp    <= nexp;
            s1_frac   <= norm[W-3 -: C_MANT];
            s1_guard  <= norm[W-2-MW];
            s1_sticky <= st | (|norm[W-3-MW:0]);
        end
    end

    // Stage 2: round and pack
    logic           inc, ovf, max_fin, nx, uf;
    logic [SW-1:0]  sum;
    logic [EW:0]    rexp;
    logic [RW-1:0]  res;

    always_comb begin
        case (s1_rm)
            3'd1:    inc = 1'b0;
            3'd2:    inc = s1_sign & (s1_guard | s1_sticky);
            3'd3:    inc = !s1_sign & (s1_guard | s1_sticky);
            3'd4:    inc = s1_guard;
            default: inc = s1_guard & (s1_sticky | s1_frac[0]);
        endcase
        // Carry out of the fraction bumps the exponent; from a subnormal this lands on the min normal.
        sum     = {1'b0, s1_exp, s1_frac} + SW'(inc);
        rexp    = sum[SW-1 -: EW+1];
        ovf     = rexp >= (EW+1)'(2**C_EXP - 1);
        max_fin = (s1_rm == 3'd1) | ((s1_rm == 3'd2) & !s1_sign) | ((s1_rm == 3'd3) & s1_sign);
        if (ovf) begin
            res = max_fin ? {s1_sign, {(C_EXP-1){1'b1}}, 1'b0, {C_MANT{1'b1}}}
                          : {s1_sign, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
        end else begin
            res = {s1_sign, rexp[C_EXP-1:0], sum[C_MANT-1:0]};
        end
        nx = s1_guard | s1_sticky | ovf;
        uf = (s1_exp == '0) & nx;
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            Result_DO <= '0;
            OF_SO     <= 1'b0;
            UF_SO     <= 1'b0;
            NX_SO     <= 1'b0;
        end else if (s1_move) begin
            Result_DO <= res;
            OF_SO     <= ovf;
            UF_SO     <= uf;
            NX_SO     <= nx;
        end
    end

endmodule
